// File: rtl/axi_lite_pkg.sv
// Shared AXI4-Lite types, arbiter state encoding and the
// round-robin pick helper used by axi_lite_rr_arbiter.
package axi_lite_pkg;

  typedef logic [31:0] addr_t;
  typedef logic [31:0] data_t;
  typedef logic [3:0]  strb_t;
  typedef logic [1:0]  resp_t;

  localparam resp_t RESP_OKAY   = 2'b00;
  localparam resp_t RESP_SLVERR = 2'b10;

  localparam int RR_MAX   = 8;
  localparam int RR_IDX_W = 3;

  typedef enum logic [2:0] {
    IDLE,
    RADDR,
    RDATA,
    WRITE,
    WRESP,
    RSP
  } arb_state_t;

  // Smallest k wins, so last itself has lowest priority.
  function automatic logic [RR_IDX_W-1:0] rr_pick(
    input logic [RR_MAX-1:0]   req,
    input logic [RR_IDX_W-1:0] last,
    input int                  n
  );
    logic [RR_IDX_W-1:0] idx;
    rr_pick = last;
    for (int k = n; k >= 1; k--) begin
      idx = RR_IDX_W'((int'(last) + k) % n);
      if (req[idx]) rr_pick = idx;
    end
  endfunction

endpackage

// File: rtl/axi_lite_if.sv
// AXI4-Lite channel bundle with master and slave views.
interface axi_lite_if;
  import axi_lite_pkg::*;

  logic  awvalid;
  logic  awready;
  addr_t awaddr;
  logic  wvalid;
  logic  wready;
  data_t wdata;
  strb_t wstrb;
  logic  bvalid;
  logic  bready;
  resp_t bresp;
  logic  arvalid;
  logic  arready;
  addr_t araddr;
  logic  rvalid;
  logic  rready;
  data_t rdata;
  resp_t rresp;

  modport master (
    output awvalid, awaddr,
    output wvalid, wdata, wstrb,
    output bready,
    output arvalid, araddr,
    output rready,
    input  awready, wready,
    input  bvalid, bresp,
    input  arready,
    input  rvalid, rdata, rresp
  );

  modport slave (
    input  awvalid, awaddr,
    input  wvalid, wdata, wstrb,
    input  bready,
    input  arvalid, araddr,
    input  rready,
    output awready, wready,
    output bvalid, bresp,
    output arready,
    output rvalid, rdata, rresp
  );

endinterface

// File: rtl/axi_lite_rr_pick.sv
// Combinational round-robin selector: request vector and
// last grant in, winning index and any-request flag out.
module axi_lite_rr_pick
  import axi_lite_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    last,
  output logic [ID_W-1:0]    grant,
  output logic               any_req
);

  logic [RR_MAX-1:0] req_x;

  assign req_x   = RR_MAX'(req);
  assign grant   = ID_W'(rr_pick(req_x, RR_IDX_W'(last), NUM_REQ));
  assign any_req = |req;

endmodule

// File: rtl/axi_lite_rr_arbiter.sv
// Round-robin share of one AXI4-Lite master port; optional
// per-requester statistics under `AXIL_ARB_STATS_EN.
module axi_lite_rr_arbiter
  import axi_lite_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic               aclk,
  input  logic               areset_n,
  input  logic [NUM_REQ-1:0] req_valid,
  output logic [NUM_REQ-1:0] req_ready,
  input  logic [NUM_REQ-1:0] req_write,
  input  addr_t              req_addr  [NUM_REQ],
  input  data_t              req_wdata [NUM_REQ],
  input  strb_t              req_wstrb [NUM_REQ],
  output logic [NUM_REQ-1:0] rsp_valid,
  output data_t              rsp_rdata,
  output resp_t              rsp_resp,
  output logic               busy,
`ifdef AXIL_ARB_STATS_EN
  output logic [15:0]        txn_count [NUM_REQ],
  output logic [15:0]        err_count,
`endif
  axi_lite_if.master         m_axi_lite
);

  localparam logic [ID_W-1:0] LAST_INIT = ID_W'(NUM_REQ - 1);

  arb_state_t state_q, state_d;
  logic [ID_W-1:0] last_q, last_d;
  logic [ID_W-1:0] gnt_q, gnt_d;
  logic [ID_W-1:0] pick;
  logic            any_req;
  addr_t addr_q, addr_d;
  data_t wdata_q, wdata_d;
  strb_t wstrb_q, wstrb_d;
  data_t rdata_q, rdata_d;
  resp_t resp_q, resp_d;
  logic arvalid_q, arvalid_d;
  logic awvalid_q, awvalid_d;
  logic wvalid_q, wvalid_d;
  logic rready_q, rready_d;
  logic bready_q, bready_d;
  logic aw_done_q, aw_done_d;
  logic w_done_q, w_done_d;
  logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;
  logic aw_hs, w_hs;

  axi_lite_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_pick (
    .req     (req_valid),
    .last    (last_q),
    .grant   (pick),
    .any_req (any_req)
  );

  assign aw_hs = awvalid_q & m_axi_lite.awready;
  assign w_hs  = wvalid_q & m_axi_lite.wready;

  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    gnt_d       = gnt_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    rdata_d     = rdata_q;
    resp_d      = resp_q;
    arvalid_d   = arvalid_q;
    awvalid_d   = awvalid_q;
    wvalid_d    = wvalid_q;
    rready_d    = rready_q;
    bready_d    = bready_q;
    aw_done_d   = aw_done_q;
    w_done_d    = w_done_q;
    rsp_valid_d = '0;
    req_ready   = '0;
    unique case (state_q)
      IDLE: begin
        if (any_req && areset_n) begin
          req_ready[pick] = 1'b1;
          gnt_d   = pick;
          last_d  = pick;
          addr_d  = req_addr[pick];
          wdata_d = req_wdata[pick];
          wstrb_d = req_wstrb[pick];
          if (req_write[pick]) begin
            state_d   = WRITE;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            aw_done_d = 1'b0;
            w_done_d  = 1'b0;
          end else begin
            state_d   = RADDR;
            arvalid_d = 1'b1;
          end
        end
      end
      RADDR: begin
        if (m_axi_lite.arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = RDATA;
        end
      end
      RDATA: begin
        if (m_axi_lite.rvalid) begin
          rready_d           = 1'b0;
          rdata_d            = m_axi_lite.rdata;
          resp_d             = m_axi_lite.rresp;
          rsp_valid_d[gnt_q] = 1'b1;
          state_d            = RSP;
        end
      end
      WRITE: begin
        if (aw_hs) begin
          awvalid_d = 1'b0;
          aw_done_d = 1'b1;
        end
        if (w_hs) begin
          wvalid_d = 1'b0;
          w_done_d = 1'b1;
        end
        if ((aw_done_q | aw_hs) && (w_done_q | w_hs)) begin
          bready_d = 1'b1;
          state_d  = WRESP;
        end
      end
      WRESP: begin
        if (m_axi_lite.bvalid) begin
          bready_d           = 1'b0;
          resp_d             = m_axi_lite.bresp;
          rsp_valid_d[gnt_q] = 1'b1;
          state_d            = RSP;
        end
      end
      RSP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (!areset_n) begin
      state_q     <= IDLE;
      last_q      <= LAST_INIT;
      gnt_q       <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      rdata_q     <= '0;
      resp_q      <= '0;
      arvalid_q   <= 1'b0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      rready_q    <= 1'b0;
      bready_q    <= 1'b0;
      aw_done_q   <= 1'b0;
      w_done_q    <= 1'b0;
      rsp_valid_q <= '0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      gnt_q       <= gnt_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      rdata_q     <= rdata_d;
      resp_q      <= resp_d;
      arvalid_q   <= arvalid_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      rready_q    <= rready_d;
      bready_q    <= bready_d;
      aw_done_q   <= aw_done_d;
      w_done_q    <= w_done_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

`ifdef AXIL_ARB_STATS_EN
  always_ff @(posedge aclk) begin
    if (!areset_n) begin
      for (int i = 0; i < NUM_REQ; i++) txn_count[i] <= '0;
      err_count <= '0;
    end else if (state_q == RSP) begin
      if (txn_count[gnt_q] != 16'hFFFF)
        txn_count[gnt_q] <= txn_count[gnt_q] + 16'd1;
      if (resp_q != RESP_OKAY && err_count != 16'hFFFF)
        err_count <= err_count + 16'd1;
    end
  end
`endif

  assign m_axi_lite.arvalid = arvalid_q;
  assign m_axi_lite.araddr  = addr_q;
  assign m_axi_lite.awvalid = awvalid_q;
  assign m_axi_lite.awaddr  = addr_q;
  assign m_axi_lite.wvalid  = wvalid_q;
  assign m_axi_lite.wdata   = wdata_q;
  assign m_axi_lite.wstrb   = wstrb_q;
  assign m_axi_lite.rready  = rready_q;
  assign m_axi_lite.bready  = bready_q;

  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rdata_q;
  assign rsp_resp  = resp_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_axi_lite_rr_arbiter.sv
// Directed vector bench for axi_lite_rr_arbiter with a
// configurable-latency AXI4-Lite slave model.
module tb_axi_lite_rr_arbiter;
  import axi_lite_pkg::*;

  localparam int NR = 4;
  localparam int NV = 14;

  typedef struct {
    logic [3:0]  valid;
    logic [3:0]  wr;
    int          ar_dly;
    int          aw_dly;
    int          w_dly;
    resp_t       rr;
    resp_t       br;
    data_t       rd;
    int          e_gnt;
    resp_t       e_resp;
    data_t       e_rdata;
  } vec_t;

  logic          aclk;
  logic          areset_n;
  logic [NR-1:0] req_valid;
  logic [NR-1:0] req_ready;
  logic [NR-1:0] req_write;
  addr_t         req_addr  [NR];
  data_t         req_wdata [NR];
  strb_t         req_wstrb [NR];
  logic [NR-1:0] rsp_valid;
  data_t         rsp_rdata;
  resp_t         rsp_resp;
  logic          busy;
`ifdef AXIL_ARB_STATS_EN
  logic [15:0]   txn_count [NR];
  logic [15:0]   err_count;
`endif

  axi_lite_if axi ();

  axi_lite_rr_arbiter #(.NUM_REQ(NR)) dut (
    .aclk       (aclk),
    .areset_n   (areset_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_wstrb  (req_wstrb),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_resp   (rsp_resp),
    .busy       (busy),
`ifdef AXIL_ARB_STATS_EN
    .txn_count  (txn_count),
    .err_count  (err_count),
`endif
    .m_axi_lite (axi)
  );

  initial begin
    aclk = 1'b0;
    forever #5 aclk = ~aclk;
  end

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h",
               name, act, exp);
    end
  endtask

  function automatic logic [3:0] oh(input int g);
    logic [3:0] one;
    one = 4'b0001;
    return one << g;
  endfunction

  // Slave model configuration
  int    ar_dly = 0, aw_dly = 0, w_dly = 0;
  logic  r_stall = 1'b0;
  data_t s_rdata = '0;
  resp_t s_rresp = '0, s_bresp = '0;

  int    ar_w, aw_w, w_w;
  logic  r_pend, aw_got, w_got;
  addr_t aw_cap;
  data_t wd_cap;
  strb_t ws_cap;

  always @(posedge aclk) begin
    if (!areset_n) begin
      axi.arready <= 1'b0;
      axi.awready <= 1'b0;
      axi.wready  <= 1'b0;
      axi.rvalid  <= 1'b0;
      axi.bvalid  <= 1'b0;
      axi.rdata   <= '0;
      axi.rresp   <= '0;
      axi.bresp   <= '0;
      ar_w <= 0; aw_w <= 0; w_w <= 0;
      r_pend <= 1'b0; aw_got <= 1'b0; w_got <= 1'b0;
    end else begin
      if (axi.arvalid && !axi.arready) begin
        if (ar_w >= ar_dly) begin
          axi.arready <= 1'b1; ar_w <= 0;
        end else ar_w <= ar_w + 1;
      end else axi.arready <= 1'b0;
      if (axi.arvalid && axi.arready) r_pend <= 1'b1;
      if (r_pend && !axi.rvalid && !r_stall) begin
        axi.rvalid <= 1'b1;
        axi.rdata  <= s_rdata;
        axi.rresp  <= s_rresp;
      end
      if (axi.rvalid && axi.rready) begin
        axi.rvalid <= 1'b0; r_pend <= 1'b0;
      end
      if (axi.awvalid && !axi.awready) begin
        if (aw_w >= aw_dly) begin
          axi.awready <= 1'b1; aw_w <= 0;
        end else aw_w <= aw_w + 1;
      end else axi.awready <= 1'b0;
      if (axi.awvalid && axi.awready) begin
        aw_got <= 1'b1; aw_cap <= axi.awaddr;
      end
      if (axi.wvalid && !axi.wready) begin
        if (w_w >= w_dly) begin
          axi.wready <= 1'b1; w_w <= 0;
        end else w_w <= w_w + 1;
      end else axi.wready <= 1'b0;
      if (axi.wvalid && axi.wready) begin
        w_got <= 1'b1;
        wd_cap <= axi.wdata; ws_cap <= axi.wstrb;
      end
      if (aw_got && w_got && !axi.bvalid) begin
        axi.bvalid <= 1'b1; axi.bresp <= s_bresp;
      end
      if (axi.bvalid && axi.bready) begin
        axi.bvalid <= 1'b0;
        aw_got <= 1'b0; w_got <= 1'b0;
      end
    end
  end

  // Protocol monitor: valids and payloads hold until handshake
  int    ar_viol = 0, aw_viol = 0, w_viol = 0;
  int    rdy_viol = 0, b_viol = 0;
  logic  p_rst = 1'b0;
  logic  p_arv = 1'b0, p_arr = 1'b0;
  logic  p_awv = 1'b0, p_awr = 1'b0;
  logic  p_wv = 1'b0, p_wr = 1'b0;
  addr_t p_araddr, p_awaddr;
  data_t p_wdata;
  strb_t p_wstrb;

  always @(negedge aclk) begin
    if (areset_n && p_rst) begin
      if (p_arv && !p_arr &&
          (!axi.arvalid || axi.araddr != p_araddr))
        ar_viol <= ar_viol + 1;
      if (p_awv && !p_awr &&
          (!axi.awvalid || axi.awaddr != p_awaddr))
        aw_viol <= aw_viol + 1;
      if (p_wv && !p_wr &&
          (!axi.wvalid || axi.wdata != p_wdata ||
           axi.wstrb != p_wstrb))
        w_viol <= w_viol + 1;
    end
    if (busy && req_ready != '0) rdy_viol <= rdy_viol + 1;
    if (axi.bready && !(aw_got && w_got))
      b_viol <= b_viol + 1;
    p_rst    <= areset_n;
    p_arv    <= axi.arvalid;
    p_arr    <= axi.arready;
    p_awv    <= axi.awvalid;
    p_awr    <= axi.awready;
    p_wv     <= axi.wvalid;
    p_wr     <= axi.wready;
    p_araddr <= axi.araddr;
    p_awaddr <= axi.awaddr;
    p_wdata  <= axi.wdata;
    p_wstrb  <= axi.wstrb;
  end

  initial begin
    #400000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  vec_t vecs [NV];

  initial begin
    vec_t v;
    int   n;

    vecs[0]  = '{4'b0001, 4'b0000, 0, 0, 0, 2'b00, 2'b00,
                 32'hDEADBEEF, 0, 2'b00, 32'hDEADBEEF};
    vecs[1]  = '{4'b1000, 4'b0000, 0, 0, 0, 2'b00, 2'b00,
                 32'hA0000003, 3, 2'b00, 32'hA0000003};
    vecs[2]  = '{4'b1111, 4'b0000, 1, 0, 0, 2'b00, 2'b00,
                 32'hB0000000, 0, 2'b00, 32'hB0000000};
    vecs[3]  = '{4'b1111, 4'b0000, 0, 0, 0, 2'b00, 2'b00,
                 32'hB0000001, 1, 2'b00, 32'hB0000001};
    vecs[4]  = '{4'b1111, 4'b0000, 2, 0, 0, 2'b00, 2'b00,
                 32'hB0000002, 2, 2'b00, 32'hB0000002};
    vecs[5]  = '{4'b1111, 4'b0000, 0, 0, 0, 2'b00, 2'b00,
                 32'hB0000003, 3, 2'b00, 32'hB0000003};
    vecs[6]  = '{4'b1111, 4'b0000, 0, 0, 0, 2'b00, 2'b00,
                 32'hB0000004, 0, 2'b00, 32'hB0000004};
    vecs[7]  = '{4'b0010, 4'b0010, 0, 0, 3, 2'b00, 2'b00,
                 32'h0, 1, 2'b00, 32'hB0000004};
    vecs[8]  = '{4'b0010, 4'b0010, 0, 3, 0, 2'b00, 2'b00,
                 32'h0, 1, 2'b00, 32'hB0000004};
    vecs[9]  = '{4'b0010, 4'b0010, 0, 0, 0, 2'b00, 2'b10,
                 32'h0, 1, 2'b10, 32'hB0000004};
    vecs[10] = '{4'b0100, 4'b0000, 0, 0, 0, 2'b10, 2'b00,
                 32'hC0000000, 2, 2'b10, 32'hC0000000};
    vecs[11] = '{4'b0100, 4'b0000, 0, 0, 0, 2'b00, 2'b00,
                 32'hC0000001, 2, 2'b00, 32'hC0000001};
    vecs[12] = '{4'b0110, 4'b0000, 0, 0, 0, 2'b00, 2'b00,
                 32'hC0000002, 1, 2'b00, 32'hC0000002};
    vecs[13] = '{4'b1111, 4'b1111, 0, 2, 1, 2'b00, 2'b00,
                 32'h0, 2, 2'b00, 32'hC0000002};

    for (int i = 0; i < NR; i++) begin
      req_addr[i]  = 32'h4 + 32'(4 * i);
      req_wdata[i] = 32'hA5A50000 | 32'(i);
      req_wstrb[i] = 4'hF;
    end
    req_wdata[1] = 32'h12345678;
    req_wstrb[2] = 4'h3;

    areset_n  = 1'b0;
    req_valid = 4'b1111;
    req_write = 4'b0000;
    repeat (3) @(negedge aclk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_arvalid", 32'(axi.arvalid), 32'd0);
    chk("rst_awvalid", 32'(axi.awvalid), 32'd0);
    chk("rst_wvalid", 32'(axi.wvalid), 32'd0);
    chk("rst_rready", 32'(axi.rready), 32'd0);
    chk("rst_bready", 32'(axi.bready), 32'd0);
    chk("rst_araddr", axi.araddr, 32'd0);
    chk("rst_wdata", axi.wdata, 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    chk("rst_rsp_resp", 32'(rsp_resp), 32'd0);

    areset_n = 1'b1;
    for (int i = 0; i < NV; i++) begin
      v = vecs[i];
      ar_dly  = v.ar_dly;
      aw_dly  = v.aw_dly;
      w_dly   = v.w_dly;
      s_rresp = v.rr;
      s_bresp = v.br;
      s_rdata = v.rd;
      req_valid = v.valid;
      req_write = v.wr;
      #1;
      n = 0;
      while (req_ready == 4'b0 && n < 50) begin
        @(negedge aclk); #1; n++;
      end
      chk($sformatf("v%0d_grant", i),
          32'(req_ready), 32'(oh(v.e_gnt)));
      n = 0;
      do begin
        @(negedge aclk); #1; n++;
      end while (rsp_valid == 4'b0 && n < 100);
      chk($sformatf("v%0d_rsp_valid", i),
          32'(rsp_valid), 32'(oh(v.e_gnt)));
      chk($sformatf("v%0d_rdata", i), rsp_rdata, v.e_rdata);
      chk($sformatf("v%0d_resp", i),
          32'(rsp_resp), 32'(v.e_resp));
      if (v.wr[v.e_gnt]) begin
        chk($sformatf("v%0d_awaddr", i),
            aw_cap, req_addr[v.e_gnt]);
        chk($sformatf("v%0d_wdata", i),
            wd_cap, req_wdata[v.e_gnt]);
        chk($sformatf("v%0d_wstrb", i),
            32'(ws_cap), 32'(req_wstrb[v.e_gnt]));
      end
      @(negedge aclk); #1;
      chk($sformatf("v%0d_rsp_pulse", i),
          32'(rsp_valid), 32'd0);
    end
    req_valid = 4'b0000;
    req_write = 4'b0000;

`ifdef AXIL_ARB_STATS_EN
    chk("stats_txn0", 32'(txn_count[0]), 32'd3);
    chk("stats_txn1", 32'(txn_count[1]), 32'd5);
    chk("stats_txn2", 32'(txn_count[2]), 32'd4);
    chk("stats_txn3", 32'(txn_count[3]), 32'd2);
    chk("stats_err", 32'(err_count), 32'd2);
`endif

    // Reset while the slave stalls the read data channel
    ar_dly  = 0;
    r_stall = 1'b1;
    s_rresp = 2'b00;
    @(negedge aclk);
    req_valid = 4'b0100;
    #1;
    n = 0;
    while (req_ready == 4'b0 && n < 50) begin
      @(negedge aclk); #1; n++;
    end
    chk("t5_grant", 32'(req_ready), 32'b0100);
    n = 0;
    while (!axi.rready && n < 50) begin
      @(negedge aclk); #1; n++;
    end
    chk("t5_in_rdata", 32'(axi.rready), 32'd1);
    areset_n = 1'b0;
    @(posedge aclk); #1;
    chk("t5_arvalid", 32'(axi.arvalid), 32'd0);
    chk("t5_rready", 32'(axi.rready), 32'd0);
    chk("t5_awvalid", 32'(axi.awvalid), 32'd0);
    chk("t5_bready", 32'(axi.bready), 32'd0);
    chk("t5_busy", 32'(busy), 32'd0);
    chk("t5_req_ready", 32'(req_ready), 32'd0);
    @(negedge aclk);
    areset_n  = 1'b1;
    r_stall   = 1'b0;
    s_rdata   = 32'h5A5A0000;
    req_valid = 4'b1111;
    #1;
    chk("t5_regrant", 32'(req_ready), 32'b0001);
    n = 0;
    do begin
      @(negedge aclk); #1; n++;
    end while (rsp_valid == 4'b0 && n < 100);
    req_valid = 4'b0000;
    chk("t5_rsp_valid", 32'(rsp_valid), 32'b0001);
    chk("t5_rdata", rsp_rdata, 32'h5A5A0000);
    @(negedge aclk); #1;

    // Long ARREADY stall with other requesters pending
    ar_dly    = 20;
    s_rdata   = 32'h0BADF00D;
    req_valid = 4'b0111;
    #1;
    n = 0;
    while (req_ready == 4'b0 && n < 50) begin
      @(negedge aclk); #1; n++;
    end
    chk("t6_grant", 32'(req_ready), 32'b0010);
    @(negedge aclk); #1;
    chk("t6_araddr", axi.araddr, req_addr[1]);
    n = 0;
    while (axi.arvalid && !axi.arready && n < 100) begin
      @(negedge aclk); #1; n++;
    end
    chk("t6_stall_ge20", 32'(n >= 20), 32'd1);
    n = 0;
    do begin
      @(negedge aclk); #1; n++;
    end while (rsp_valid == 4'b0 && n < 100);
    req_valid = 4'b0000;
    chk("t6_rsp_valid", 32'(rsp_valid), 32'b0010);
    chk("t6_rdata", rsp_rdata, 32'h0BADF00D);
    @(negedge aclk); #1;

`ifdef AXIL_ARB_STATS_EN
    chk("t6_txn0", 32'(txn_count[0]), 32'd1);
    chk("t6_txn1", 32'(txn_count[1]), 32'd1);
    chk("t6_txn2", 32'(txn_count[2]), 32'd0);
    chk("t6_err", 32'(err_count), 32'd0);
`endif

    chk("mon_ar_stable", 32'(ar_viol), 32'd0);
    chk("mon_aw_stable", 32'(aw_viol), 32'd0);
    chk("mon_w_stable", 32'(w_viol), 32'd0);
    chk("mon_ready_busy", 32'(rdy_viol), 32'd0);
    chk("mon_bready_early", 32'(b_viol), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
